// File: rtl/decoder_sel_sequencer.sv
// Select sequencer for the 3-to-8 decoder: sweeps {a,b,c} through all eight
// codes with a programmable dwell, single-pass or looping, up or down.
module decoder_sel_sequencer #(
    parameter int DWELL_W = 8,
    parameter int PASS_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               enb,
    output logic               step,
    output logic               busy,
    output logic               done,
    output logic [PASS_W-1:0]  pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0]  PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_next;
    logic [2:0]         r_sel, w_sel_next;
    logic [DWELL_W-1:0] r_cnt, w_cnt_next;
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;
    logic [PASS_W-1:0]  r_pass, w_pass_next;
    logic               r_dir, w_dir_next;
    logic               r_loop, w_loop_next;
    logic               r_enb, w_enb_next;
    logic               r_step, w_step_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_start_ok;
    logic               w_last;
    logic               w_terminal;
    logic [2:0]         w_sel_adv;

    // A zero dwell behaves as one; advance wraps naturally in 3 bits.
    assign w_dwell_eff = (dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell;
    assign w_start_ok  = start && !stop;
    assign w_last      = (r_cnt <= DWELL_ONE);
    assign w_terminal  = r_dir ? (r_sel == 3'd0) : (r_sel == 3'd7);
    assign w_sel_adv   = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_next = S_RUN;
                else            w_state_next = S_IDLE;
            end
            S_RUN: begin
                if (stop)                              w_state_next = S_IDLE;
                else if (w_last && w_terminal && !r_loop) w_state_next = S_DONE;
                else                                   w_state_next = S_RUN;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and latched sweep settings
    always_comb begin
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_pass_next  = r_pass;
        w_dir_next   = r_dir;
        w_loop_next  = r_loop;
        w_dwell_next = r_dwell;
        w_enb_next   = 1'b0;
        w_step_next  = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_sel_next   = dir ? 3'd7 : 3'd0;
                    w_cnt_next   = w_dwell_eff;
                    w_pass_next  = {PASS_W{1'b0}};
                    w_dir_next   = dir;
                    w_loop_next  = loop;
                    w_dwell_next = w_dwell_eff;
                    w_enb_next   = 1'b1;
                    w_busy_next  = 1'b1;
                    w_step_next  = 1'b1;
                end else begin
                    w_enb_next   = 1'b0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_enb_next  = 1'b0;
                end else if (!w_last) begin
                    w_cnt_next  = r_cnt - DWELL_ONE;
                    w_enb_next  = 1'b1;
                    w_busy_next = 1'b1;
                end else if (!w_terminal || r_loop) begin
                    w_sel_next  = w_sel_adv;
                    w_cnt_next  = r_dwell;
                    w_enb_next  = 1'b1;
                    w_busy_next = 1'b1;
                    w_step_next = 1'b1;
                    if (w_terminal) w_pass_next = r_pass + PASS_ONE;
                    else            w_pass_next = r_pass;
                end else begin
                    w_pass_next = r_pass + PASS_ONE;
                    w_done_next = 1'b1;
                end
            end
            S_DONE: begin
                w_enb_next = 1'b0;
            end
            default: begin
                w_enb_next = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= 3'd0;
            r_cnt   <= {DWELL_W{1'b0}};
            r_dwell <= {DWELL_W{1'b0}};
            r_pass  <= {PASS_W{1'b0}};
            r_dir   <= 1'b0;
            r_loop  <= 1'b0;
            r_enb   <= 1'b0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sel   <= w_sel_next;
            r_cnt   <= w_cnt_next;
            r_dwell <= w_dwell_next;
            r_pass  <= w_pass_next;
            r_dir   <= w_dir_next;
            r_loop  <= w_loop_next;
            r_enb   <= w_enb_next;
            r_step  <= w_step_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign {a, b, c} = r_sel;
    assign enb       = r_enb;
    assign step      = r_step;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass_cnt  = r_pass;

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Directed bench: expected per-cycle output vectors are queued when stimulus
// is set up and popped/compared one clock at a time.
module tb_decoder_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, dir, loop;
    logic [7:0] dwell;
    logic       a, b, c, enb, step, busy, done;
    logic [7:0] pass_cnt;

    logic [14:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    decoder_sel_sequencer #(.DWELL_W(8), .PASS_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .loop(loop), .dwell(dwell), .a(a), .b(b), .c(c), .enb(enb),
        .step(step), .busy(busy), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {sel, enb, step, busy, done, pass_cnt}
    task automatic push(input logic [2:0] sel, input logic e, input logic s,
                        input logic bz, input logic d, input logic [7:0] p);
        exp_q.push_back({sel, e, s, bz, d, p});
    endtask

    // One non-looping pass, then the DONE cycle and one IDLE cycle after it
    task automatic push_pass(input logic dn, input int dw);
        logic [2:0] code;
        for (int k = 0; k < 8; k++) begin
            code = dn ? 3'(7 - k) : 3'(k);
            for (int j = 0; j < dw; j++) push(code, 1'b1, (j == 0), 1'b1, 1'b0, 8'd0);
        end
        push(dn ? 3'd0 : 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        push(dn ? 3'd0 : 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    endtask

    task automatic check(input string tag);
        logic [14:0] obs, expv;
        @(posedge clk);
        #1;
        obs = {a, b, c, enb, step, busy, done, pass_cnt};
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) n_pass++;
            else $error("FAIL %s obs sel=%0d e/s/b/d=%b pass=%0d exp sel=%0d e/s/b/d=%b pass=%0d",
                        tag, obs[14:12], obs[11:8], obs[7:0],
                        expv[14:12], expv[11:8], expv[7:0]);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) check(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; loop = 1'b0; dwell = 8'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("reset");
        rst = 1'b0;

        // Up sweep, dwell 2
        push_pass(1'b0, 2);
        dir = 1'b0; loop = 1'b0; dwell = 8'd2; start = 1'b1;
        check("up_dw2");
        start = 1'b0;
        drain("up_dw2");

        // Down sweep, dwell 1
        push_pass(1'b1, 1);
        dir = 1'b1; dwell = 8'd1; start = 1'b1;
        check("down_dw1");
        start = 1'b0;
        drain("down_dw1");

        // Dwell 0 acts as dwell 1
        push_pass(1'b0, 1);
        dir = 1'b0; dwell = 8'd0; start = 1'b1;
        check("dw0");
        start = 1'b0;
        drain("dw0");

        // Looping sweep for 20 cycles, then stop
        for (int k = 0; k < 20; k++) push(3'(k % 8), 1'b1, 1'b1, 1'b1, 1'b0, 8'(k / 8));
        loop = 1'b1; dwell = 8'd1; start = 1'b1;
        check("loop");
        start = 1'b0;
        drain("loop");
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        stop = 1'b1;
        check("loop_stop");
        stop = 1'b0;
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        check("after_stop");

        // Reset mid-sweep at sel=5 after one wrap
        for (int k = 0; k < 14; k++) push(3'(k % 8), 1'b1, 1'b1, 1'b1, 1'b0, 8'(k / 8));
        start = 1'b1;
        check("pre_rst");
        start = 1'b0;
        drain("pre_rst");
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        check("mid_rst");
        rst = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("post_rst");

        // Mid-sweep start and setting changes are ignored
        push_pass(1'b0, 2);
        dir = 1'b0; loop = 1'b0; dwell = 8'd2; start = 1'b1;
        check("ignore");
        dwell = 8'd5; dir = 1'b1; loop = 1'b1;
        for (int k = 0; k < 3; k++) check("ignore");
        start = 1'b0;
        drain("ignore");

        // start and stop together in IDLE
        push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        start = 1'b1; stop = 1'b1;
        check("start_stop");
        check("start_stop");
        start = 1'b0; stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
